wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back end of the MEM/WB interface for the dual-issue pipeline: consumes both MEM/WB write slots and both NZCV flag sets.
- Holds the 8-entry 32-bit architectural register file and the NZCV flag register.
- Supplies four decode-stage read ports, with same-cycle write-to-read bypass so decode never sees stale data.
- Slot 2 (inst2) is younger in program order than slot 1 (inst1); inst2 wins every conflict.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 3, register address width
- NUM_REGS, 8, number of architectural registers (2**ADDR_W)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- regWrite1  in  1  slot-1 register write enable
- DestReg1  in  ADDR_W  slot-1 destination register
- WriteData1  in  DATA_W  slot-1 write data
- regWrite2  in  1  slot-2 register write enable
- DestReg2  in  ADDR_W  slot-2 destination register
- WriteData2  in  DATA_W  slot-2 write data
- flagWrite1  in  1  slot-1 flag update enable
- inst1Flags  in  4  slot-1 {N,Z,C,V}
- flagWrite2  in  1  slot-2 flag update enable
- inst2Flags  in  4  slot-2 {N,Z,C,V}
- rdAddr0..rdAddr3  in  ADDR_W each  decode read addresses
- rdData0..rdData3  out  DATA_W each  decode read data (combinational)
- flagsOut  out  4  registered NZCV
- flagsNext  out  4  bypassed NZCV, for the branch unit in decode

Behaviour:
- Single clock domain. Reset is synchronous, active-high, on clk rising edge.
- Reset: all NUM_REGS entries go to 0; flag register goes to 4'b0000. Reset has priority over any write in the same cycle.
  - While reset is high, bypass is suppressed: rdData returns array contents, flagsNext equals flagsOut.
  - First write is accepted on the first edge with reset low.
- Register writes, on the rising edge:
  - regWrite1 only: reg[DestReg1] <= WriteData1.
  - regWrite2 only: reg[DestReg2] <= WriteData2.
  - Both enabled, different destinations: both writes commit in the same edge.
  - Both enabled, DestReg1 == DestReg2: WriteData2 is stored; WriteData1 is discarded.
- No hardwired-zero register; all 8 entries are writable.
- Reads are combinational, zero latency. For each port k, rdData_k is chosen in priority order:
  - (reset low) AND regWrite2 AND rdAddr_k == DestReg2 -> WriteData2.
  - else (reset low) AND regWrite1 AND rdAddr_k == DestReg1 -> WriteData1.
  - else reg[rdAddr_k].
- All four ports are independent; any number of ports may alias the same address.
- Flags, on the rising edge:
  - flagWrite2 -> flags <= inst2Flags.
  - else flagWrite1 -> flags <= inst1Flags.
  - else hold.
  - All four bits update together; there are no partial flag writes.
- flagsNext uses the same priority as the flag register (flagWrite2 first, then flagWrite1), otherwise flagsOut. One-cycle visibility of flagsOut after the write edge.
- Register-write enables and flag-write enables are independent. A slot may write flags without a register and vice versa.
- Inputs are sampled only at the clock edge. No handshake: WB always accepts; there is no backpressure.
- X on DestReg/WriteData while the matching enable is low must not corrupt state or bypass.

Test Plan:
1. Reset, then read all 8 addresses -> all 0. flagsOut = flagsNext = 0000.
2. regWrite1=1, DestReg1=3, WriteData1=0xDEADBEEF; rdAddr0=3 in the same cycle -> rdData0 = 0xDEADBEEF (bypass). Next cycle, with no writes -> rdData0 = 0xDEADBEEF (from array).
3. Both slots write DestReg=5, WriteData1=0x11111111, WriteData2=0x22222222; rdAddr1=5 -> 0x22222222 in the same cycle, and 0x22222222 after the edge. Also both slots write regs 1 and 2 with 0xA and 0xB -> both stored.
4. flagWrite1=1 (1000) and flagWrite2=1 (0100) -> flagsNext = 0100 in the same cycle, flagsOut = 0100 next cycle. Then flagWrite1 only with 0011 -> flagsOut = 0011. Then no flag writes for 3 cycles -> flagsOut holds 0011.
5. reg7 = 0x5A5A5A5A, then assert reset together with regWrite2=1 to reg7 = 0xFFFFFFFF, rdAddr2=7 -> rdData2 = 0x5A5A5A5A that cycle (bypass suppressed), 0 after the edge, flags 0000.
6. Four ports reading 3,3,6,0 while regWrite1 targets reg 6 -> ports 0 and 1 return the reg-3 array value, port 2 returns WriteData1, port 3 returns reg 0.

Source files
------------

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB write slots, flag updates and decode-stage read ports of the register file
interface wb_regfile_if #(parameter int DATA_W = 32, parameter int ADDR_W = 3);
   logic              regWrite1, regWrite2, flagWrite1, flagWrite2;
   logic [ADDR_W-1:0] DestReg1, DestReg2;
   logic [DATA_W-1:0] WriteData1, WriteData2;
   logic [3:0]        inst1Flags, inst2Flags;
   logic [ADDR_W-1:0] rdAddr0, rdAddr1, rdAddr2, rdAddr3;
   logic [DATA_W-1:0] rdData0, rdData1, rdData2, rdData3;
   logic [3:0]        flagsOut, flagsNext;
   modport master (
      output regWrite1, DestReg1, WriteData1, regWrite2, DestReg2, WriteData2,
      output flagWrite1, inst1Flags, flagWrite2, inst2Flags,
      output rdAddr0, rdAddr1, rdAddr2, rdAddr3,
      input  rdData0, rdData1, rdData2, rdData3, flagsOut, flagsNext
   );
   modport slave (
      input  regWrite1, DestReg1, WriteData1, regWrite2, DestReg2, WriteData2,
      input  flagWrite1, inst1Flags, flagWrite2, inst2Flags,
      input  rdAddr0, rdAddr1, rdAddr2, rdAddr3,
      output rdData0, rdData1, rdData2, rdData3, flagsOut, flagsNext
   );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: dual-slot write-back register file and NZCV flags with same-cycle read bypass
module wb_regfile #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 3,
   parameter int NUM_REGS = 8
) (
   input logic        clk,
   input logic        reset,
   wb_regfile_if.slave bus
);
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [3:0]        flags, nextFlags;
   logic [ADDR_W-1:0] rdAddr [4];
   logic [DATA_W-1:0] rdData [4];
   assign rdAddr = '{bus.rdAddr0, bus.rdAddr1, bus.rdAddr2, bus.rdAddr3};
   // slot 2 is younger, so its write is checked first for bypass
   always_comb begin
      for (int k = 0; k < 4; k++)
         rdData[k] = (!reset && bus.regWrite2 && rdAddr[k] == bus.DestReg2) ? bus.WriteData2 :
                     (!reset && bus.regWrite1 && rdAddr[k] == bus.DestReg1) ? bus.WriteData1 :
                     regs[rdAddr[k]];
   end
   assign nextFlags     = bus.flagWrite2 ? bus.inst2Flags : bus.flagWrite1 ? bus.inst1Flags : flags;
   assign bus.rdData0   = rdData[0];
   assign bus.rdData1   = rdData[1];
   assign bus.rdData2   = rdData[2];
   assign bus.rdData3   = rdData[3];
   assign bus.flagsOut  = flags;
   assign bus.flagsNext = reset ? flags : nextFlags;
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         flags <= '0;
      end else begin
         if (bus.regWrite1) regs[bus.DestReg1] <= bus.WriteData1;
         if (bus.regWrite2) regs[bus.DestReg2] <= bus.WriteData2;
         flags <= nextFlags;
      end
   end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and randomized checks of wb_regfile against an array-based model
module tb_wb_regfile;
   logic clk = 0, reset;
   int errors = 0, checks = 0;
   logic [31:0] model [8];
   logic [3:0]  mFlags;
   wb_regfile_if bus ();
   wb_regfile dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic idle();
      bus.regWrite1 = 0; bus.regWrite2 = 0; bus.flagWrite1 = 0; bus.flagWrite2 = 0;
      bus.DestReg1 = 'x; bus.DestReg2 = 'x; bus.WriteData1 = 'x; bus.WriteData2 = 'x;
      bus.inst1Flags = 'x; bus.inst2Flags = 'x;
   endtask
   // model follows the write rules, then the edge is taken
   task automatic tick();
      if (reset) begin
         foreach (model[i]) model[i] = '0;
         mFlags = '0;
      end else begin
         if (bus.regWrite1) model[bus.DestReg1] = bus.WriteData1;
         if (bus.regWrite2) model[bus.DestReg2] = bus.WriteData2;
         if (bus.flagWrite2) mFlags = bus.inst2Flags;
         else if (bus.flagWrite1) mFlags = bus.inst1Flags;
      end
      @(posedge clk);
      #1;
   endtask
   function automatic logic [31:0] expRd(logic [2:0] a);
      if (!reset && bus.regWrite2 && a == bus.DestReg2) return bus.WriteData2;
      if (!reset && bus.regWrite1 && a == bus.DestReg1) return bus.WriteData1;
      return model[a];
   endfunction
   task automatic test_reset();
      idle();
      reset = 1;
      bus.rdAddr0 = 0; bus.rdAddr1 = 0; bus.rdAddr2 = 0; bus.rdAddr3 = 0;
      tick();
      tick();
      reset = 0;
      for (int a = 0; a < 8; a++) begin
         bus.rdAddr0 = 3'(a);
         #1;
         checks++;
         if (bus.rdData0 !== 32'h0) begin
            errors++;
            $display("FAIL reset_reg%0d got=%h exp=0", a, bus.rdData0);
         end
      end
      checks++;
      if (bus.flagsOut !== 4'b0000 || bus.flagsNext !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got=%b/%b exp=0000/0000", bus.flagsOut, bus.flagsNext);
      end
   endtask
   task automatic test_bypass();
      idle();
      bus.regWrite1 = 1; bus.DestReg1 = 3; bus.WriteData1 = 32'hDEADBEEF; bus.rdAddr0 = 3;
      #1;
      checks++;
      if (bus.rdData0 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL bypass_same_cycle got=%h exp=deadbeef", bus.rdData0);
      end
      tick();
      idle();
      #1;
      checks++;
      if (bus.rdData0 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL bypass_array got=%h exp=deadbeef", bus.rdData0);
      end
   endtask
   task automatic test_dual_write();
      idle();
      bus.regWrite1 = 1; bus.DestReg1 = 5; bus.WriteData1 = 32'h11111111;
      bus.regWrite2 = 1; bus.DestReg2 = 5; bus.WriteData2 = 32'h22222222;
      bus.rdAddr1 = 5;
      #1;
      checks++;
      if (bus.rdData1 !== 32'h22222222) begin
         errors++;
         $display("FAIL same_dest_bypass got=%h exp=22222222", bus.rdData1);
      end
      tick();
      idle();
      #1;
      checks++;
      if (bus.rdData1 !== 32'h22222222) begin
         errors++;
         $display("FAIL same_dest_stored got=%h exp=22222222", bus.rdData1);
      end
      bus.regWrite1 = 1; bus.DestReg1 = 1; bus.WriteData1 = 32'hA;
      bus.regWrite2 = 1; bus.DestReg2 = 2; bus.WriteData2 = 32'hB;
      tick();
      idle();
      bus.rdAddr0 = 1; bus.rdAddr1 = 2;
      #1;
      checks++;
      if (bus.rdData0 !== 32'hA || bus.rdData1 !== 32'hB) begin
         errors++;
         $display("FAIL dual_dest got=%h/%h exp=0000000a/0000000b", bus.rdData0, bus.rdData1);
      end
   endtask
   task automatic test_flags();
      idle();
      bus.flagWrite1 = 1; bus.inst1Flags = 4'b1000;
      bus.flagWrite2 = 1; bus.inst2Flags = 4'b0100;
      #1;
      checks++;
      if (bus.flagsNext !== 4'b0100) begin
         errors++;
         $display("FAIL flags_next_both got=%b exp=0100", bus.flagsNext);
      end
      tick();
      idle();
      checks++;
      if (bus.flagsOut !== 4'b0100) begin
         errors++;
         $display("FAIL flags_out_both got=%b exp=0100", bus.flagsOut);
      end
      bus.flagWrite1 = 1; bus.inst1Flags = 4'b0011;
      tick();
      idle();
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (bus.flagsOut !== 4'b0011 || bus.flagsNext !== 4'b0011) begin
            errors++;
            $display("FAIL flags_hold%0d got=%b/%b exp=0011/0011", c, bus.flagsOut, bus.flagsNext);
         end
         tick();
      end
   endtask
   task automatic test_reset_priority();
      idle();
      bus.regWrite1 = 1; bus.DestReg1 = 7; bus.WriteData1 = 32'h5A5A5A5A;
      tick();
      idle();
      reset = 1;
      bus.regWrite2 = 1; bus.DestReg2 = 7; bus.WriteData2 = 32'hFFFFFFFF;
      bus.flagWrite2 = 1; bus.inst2Flags = 4'b1111;
      bus.rdAddr2 = 7;
      #1;
      checks++;
      if (bus.rdData2 !== 32'h5A5A5A5A || bus.flagsNext !== 4'b0011) begin
         errors++;
         $display("FAIL reset_no_bypass got=%h/%b exp=5a5a5a5a/0011", bus.rdData2, bus.flagsNext);
      end
      tick();
      reset = 0;
      idle();
      #1;
      checks++;
      if (bus.rdData2 !== 32'h0 || bus.flagsOut !== 4'b0000) begin
         errors++;
         $display("FAIL reset_wins got=%h/%b exp=00000000/0000", bus.rdData2, bus.flagsOut);
      end
   endtask
   task automatic test_multiport();
      idle();
      bus.regWrite1 = 1; bus.DestReg1 = 3; bus.WriteData1 = 32'h33333333;
      bus.regWrite2 = 1; bus.DestReg2 = 0; bus.WriteData2 = 32'h0C0C0C0C;
      tick();
      idle();
      bus.regWrite1 = 1; bus.DestReg1 = 6; bus.WriteData1 = 32'h66666666;
      bus.rdAddr0 = 3; bus.rdAddr1 = 3; bus.rdAddr2 = 6; bus.rdAddr3 = 0;
      #1;
      checks++;
      if (bus.rdData0 !== 32'h33333333 || bus.rdData1 !== 32'h33333333 ||
          bus.rdData2 !== 32'h66666666 || bus.rdData3 !== 32'h0C0C0C0C) begin
         errors++;
         $display("FAIL multiport got=%h/%h/%h/%h exp=33333333/33333333/66666666/0c0c0c0c",
                  bus.rdData0, bus.rdData1, bus.rdData2, bus.rdData3);
      end
      tick();
      idle();
   endtask
   task automatic test_random();
      logic [31:0] act [4];
      logic [2:0]  addr [4];
      for (int n = 0; n < 300; n++) begin
         reset = ($urandom_range(0, 19) == 0);
         bus.regWrite1 = 1'($urandom); bus.DestReg1 = 3'($urandom); bus.WriteData1 = $urandom;
         bus.regWrite2 = 1'($urandom); bus.DestReg2 = 3'($urandom); bus.WriteData2 = $urandom;
         bus.flagWrite1 = 1'($urandom); bus.inst1Flags = 4'($urandom);
         bus.flagWrite2 = 1'($urandom); bus.inst2Flags = 4'($urandom);
         if (n % 3 == 0) bus.DestReg2 = bus.DestReg1;
         addr = '{3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom)};
         if (n % 4 == 0) addr[1] = bus.DestReg2;
         if (n % 4 == 1) addr[2] = bus.DestReg1;
         bus.rdAddr0 = addr[0]; bus.rdAddr1 = addr[1]; bus.rdAddr2 = addr[2]; bus.rdAddr3 = addr[3];
         #1;
         act = '{bus.rdData0, bus.rdData1, bus.rdData2, bus.rdData3};
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (act[k] !== expRd(addr[k])) begin
               errors++;
               $display("FAIL rand%0d_port%0d got=%h exp=%h", n, k, act[k], expRd(addr[k]));
            end
         end
         checks++;
         if (bus.flagsOut !== mFlags ||
             bus.flagsNext !== (reset ? mFlags : bus.flagWrite2 ? bus.inst2Flags :
                                bus.flagWrite1 ? bus.inst1Flags : mFlags)) begin
            errors++;
            $display("FAIL rand%0d_flags got=%b/%b exp_out=%b", n, bus.flagsOut, bus.flagsNext, mFlags);
         end
         tick();
      end
      reset = 0;
      idle();
   endtask
   initial begin
      test_reset();
      test_bypass();
      test_dual_write();
      test_flags();
      test_reset_priority();
      test_multiport();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
